// File: rtl/instr_fetch_unit_pkg.sv
// rtl/instr_fetch_unit_pkg.sv - shared fetch-state encodings and defaults for instr_fetch_unit
package instr_fetch_unit_pkg;

    // Fetch FSM encodings
    typedef enum logic [1:0] {
        FS_IDLE = 2'd0,
        FS_REQ  = 2'd1,
        FS_HOLD = 2'd2
    } fetch_state_t;

    localparam int DEFAULT_ADDR_W  = 32;
    localparam int DEFAULT_INSTR_W = 32;
    localparam int DEFAULT_PC_STEP = 4;

endpackage

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - instruction fetch: PC -> imem req/ack -> single-entry buffer -> decode
//
// Ports:
//   clk, reset          clock (rising edge), asynchronous active-high reset
//   pc_in / pc_next     current PC from the external PC register / next PC back to it (combinational)
//   redirect_valid/_target  taken branch/jump pulse and its target
//   imem_req/_addr      fetch request and address, held until imem_ack
//   imem_ack/_rdata     memory response
//   instr_valid/_ready  handshake to decode
//   instr_out/instr_pc  buffered instruction and its PC
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int ADDR_W  = DEFAULT_ADDR_W,
    parameter int INSTR_W = DEFAULT_INSTR_W,
    parameter int PC_STEP = DEFAULT_PC_STEP
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [ADDR_W-1:0]  pc_in,
    output logic [ADDR_W-1:0]  pc_next,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_target,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr_out,
    output logic [ADDR_W-1:0]  instr_pc
);

    fetch_state_t      state;
    logic [ADDR_W-1:0] req_addr;
    // Set when a redirect lands while a request is outstanding; the
    // eventual response belongs to the stale path and must be dropped.
    logic              discard;

    logic              fetch_done;

    assign imem_req   = (state == FS_REQ);
    assign imem_addr  = req_addr;
    assign fetch_done = (state == FS_REQ) && imem_ack && !discard;

    always_comb begin
        pc_next = pc_in;
        if (redirect_valid) begin
            pc_next = redirect_target;
        end else if (fetch_done) begin
            pc_next = pc_in + ADDR_W'(PC_STEP);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= FS_IDLE;
            req_addr    <= '0;
            discard     <= 1'b0;
            instr_out   <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
        end else begin
            case (state)
                FS_IDLE: begin
                    state    <= FS_REQ;
                    req_addr <= pc_in;
                end
                FS_REQ: begin
                    if (imem_ack) begin
                        if (redirect_valid) begin
                            // Response dropped; restart straight at the new target
                            // since the PC register only sees it next cycle.
                            discard  <= 1'b0;
                            req_addr <= redirect_target;
                        end else if (discard) begin
                            // Stale response; PC already holds the redirected value.
                            discard  <= 1'b0;
                            req_addr <= pc_in;
                        end else begin
                            instr_out   <= imem_rdata;
                            instr_pc    <= req_addr;
                            instr_valid <= 1'b1;
                            state       <= FS_HOLD;
                        end
                    end else if (redirect_valid) begin
                        // No abort on the memory side: keep the request up and
                        // throw its data away when it arrives.
                        discard <= 1'b1;
                    end
                end
                FS_HOLD: begin
                    if (redirect_valid) begin
                        instr_valid <= 1'b0;
                        state       <= FS_REQ;
                        req_addr    <= redirect_target;
                    end else if (instr_ready) begin
                        instr_valid <= 1'b0;
                        state       <= FS_REQ;
                        req_addr    <= pc_in;
                    end
                end
                default: begin
                    state <= FS_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - self-checking bench for instr_fetch_unit
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] pc_in;
    logic [31:0] pc_next;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr_out;
    logic [31:0] instr_pc;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] addr;
        int          ack_delay;
        int          ready_delay;
    } fvec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
    } exp_t;

    fvec_t vecs[4];
    exp_t  sb[$];

    instr_fetch_unit #(.ADDR_W(32), .INSTR_W(32), .PC_STEP(4)) dut (
        .clk             (clk),
        .reset           (reset),
        .pc_in           (pc_in),
        .pc_next         (pc_next),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ack        (imem_ack),
        .imem_rdata      (imem_rdata),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .instr_out       (instr_out),
        .instr_pc        (instr_pc)
    );

    always #5 clk = ~clk;

    // External PC register model
    always_ff @(posedge clk or posedge reset) begin
        if (reset) pc_in <= '0;
        else       pc_in <= pc_next;
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A3C, ~a[15:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic wait_req();
        int n = 0;
        while (!imem_req && n < 20) begin
            cyc();
            n++;
        end
        chk("req_timeout", {31'd0, imem_req}, 32'd1);
    endtask

    task automatic check_delivery();
        exp_t e;
        chk("instr_valid", {31'd0, instr_valid}, 32'd1);
        n_vec++;
        if (sb.size() == 0) begin
            n_err++;
            $display("FAIL sb_pop: got empty queue expected entry");
        end else begin
            e = sb.pop_front();
            chk("instr_pc", instr_pc, e.pc);
            chk("instr_out", instr_out, e.word);
        end
    endtask

    task automatic fetch(input fvec_t v);
        wait_req();
        chk("req_addr", imem_addr, v.addr);
        for (int i = 0; i < v.ack_delay; i++) begin
            chk("req_held", {31'd0, imem_req}, 32'd1);
            chk("addr_stable", imem_addr, v.addr);
            #1 chk("pc_next_idle", pc_next, pc_in);
            cyc();
        end
        imem_ack   = 1'b1;
        imem_rdata = mem_word(v.addr);
        #1 chk("pc_next_ack", pc_next, v.addr + 32'd4);
        sb.push_back('{pc: v.addr, word: mem_word(v.addr)});
        cyc();
        imem_ack = 1'b0;
        check_delivery();
        chk("no_req_in_hold", {31'd0, imem_req}, 32'd0);
        for (int i = 0; i < v.ready_delay; i++) begin
            chk("bp_pc_stable", instr_pc, v.addr);
            chk("bp_out_stable", instr_out, mem_word(v.addr));
            chk("bp_no_req", {31'd0, imem_req}, 32'd0);
            chk("bp_pc_held", pc_in, v.addr + 32'd4);
            cyc();
        end
        instr_ready = 1'b1;
        cyc();
        instr_ready = 1'b0;
        chk("valid_cleared", {31'd0, instr_valid}, 32'd0);
    endtask

    // Redirect while a request is outstanding, ack arrives ack_wait cycles later.
    task automatic redirect_in_req(input logic [31:0] target, input int ack_wait);
        logic [31:0] old_addr;
        wait_req();
        old_addr        = imem_addr;
        redirect_valid  = 1'b1;
        redirect_target = target;
        #1 chk("pc_next_redir", pc_next, target);
        cyc();
        redirect_valid = 1'b0;
        for (int i = 1; i < ack_wait; i++) begin
            chk("old_addr_held", imem_addr, old_addr);
            cyc();
        end
        imem_ack   = 1'b1;
        imem_rdata = mem_word(old_addr);
        #1 chk("pc_next_discard", pc_next, target);
        cyc();
        imem_ack = 1'b0;
        chk("discard_no_valid", {31'd0, instr_valid}, 32'd0);
        chk("discard_req", {31'd0, imem_req}, 32'd1);
        chk("discard_new_addr", imem_addr, target);
    endtask

    initial begin
        vecs[0] = '{addr: 32'h0,  ack_delay: 1, ready_delay: 0};
        vecs[1] = '{addr: 32'h4,  ack_delay: 1, ready_delay: 0};
        vecs[2] = '{addr: 32'h8,  ack_delay: 2, ready_delay: 5};
        vecs[3] = '{addr: 32'hC,  ack_delay: 0, ready_delay: 1};

        // Reset state
        #2;
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_addr", imem_addr, 32'd0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_out", instr_out, 32'd0);
        chk("rst_pc", instr_pc, 32'd0);
        cyc();
        cyc();
        reset = 1'b0;

        // Sequential fetches with backpressure
        for (int i = 0; i < 4; i++) fetch(vecs[i]);

        // Redirect in REQ without ack, ack 3 cycles later
        redirect_in_req(32'h100, 3);
        fetch('{addr: 32'h100, ack_delay: 1, ready_delay: 0});

        // Redirect coincident with ack
        wait_req();
        chk("req_104", imem_addr, 32'h104);
        imem_ack        = 1'b1;
        imem_rdata      = mem_word(32'h104);
        redirect_valid  = 1'b1;
        redirect_target = 32'h40;
        #1 chk("pc_next_redir_ack", pc_next, 32'h40);
        cyc();
        imem_ack       = 1'b0;
        redirect_valid = 1'b0;
        chk("redir_ack_no_valid", {31'd0, instr_valid}, 32'd0);
        chk("redir_ack_addr", imem_addr, 32'h40);

        // Redirect in HOLD
        imem_ack   = 1'b1;
        imem_rdata = mem_word(32'h40);
        sb.push_back('{pc: 32'h40, word: mem_word(32'h40)});
        cyc();
        imem_ack = 1'b0;
        check_delivery();
        redirect_valid  = 1'b1;
        redirect_target = 32'h200;
        #1 chk("pc_next_hold_redir", pc_next, 32'h200);
        cyc();
        redirect_valid = 1'b0;
        chk("hold_redir_valid", {31'd0, instr_valid}, 32'd0);
        chk("hold_redir_req", {31'd0, imem_req}, 32'd1);
        chk("hold_redir_addr", imem_addr, 32'h200);

        // Async reset mid-REQ, late ack ignored
        cyc();
        #2 reset = 1'b1;
        #1;
        chk("arst_req", {31'd0, imem_req}, 32'd0);
        chk("arst_valid", {31'd0, instr_valid}, 32'd0);
        imem_ack   = 1'b1;
        imem_rdata = mem_word(32'h200);
        cyc();
        reset = 1'b0;
        cyc();
        imem_ack = 1'b0;
        chk("late_ack_no_valid", {31'd0, instr_valid}, 32'd0);
        chk("restart_req", {31'd0, imem_req}, 32'd1);
        chk("restart_addr", imem_addr, 32'h0);
        fetch('{addr: 32'h0, ack_delay: 1, ready_delay: 0});

        // PC wrap
        redirect_in_req(32'hFFFF_FFFC, 1);
        fetch('{addr: 32'hFFFF_FFFC, ack_delay: 0, ready_delay: 0});
        fetch('{addr: 32'h0, ack_delay: 1, ready_delay: 0});

        chk("sb_empty", sb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
